// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive monitor.
//   UART_DATA_BITS : data bits per frame
//   uart_byte_t    : one received byte
//   rx_state_e     : receiver FSM states (PARITY is only reachable when
//                    UART_RX_PARITY_EN is defined)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO. The head entry is always visible on o_data;
// a pop advances to the next entry on the following cycle.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   i_push/i_data : write request and data; o_full when DEPTH entries held
//   i_pop/o_data  : read request and head data; o_empty when no entries
//   o_level       : current number of entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_full,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_rd    = i_pop && !w_empty;
  assign w_wr    = i_push && (!w_full || w_rd);

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_count;

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: decodes 8N1 frames from an asynchronous serial line,
// buffers bytes in a show-ahead FIFO and presents them on a valid/ready stream.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit between the data
// and stop bits plus the sticky err_parity_o output.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   uart_rxd_i     : serial input, idle high, asynchronous
//   rx_data_o      : head-of-FIFO byte (0 when empty)
//   rx_valid_o     : FIFO non-empty
//   rx_ready_i     : consumer accept
//   fifo_level_o   : FIFO occupancy
//   err_frame_o    : sticky framing error
//   err_overrun_o  : sticky overrun (byte dropped on full FIFO)
//   err_clr_i      : clears the sticky flags (a coincident new error wins)
//   err_parity_o   : sticky parity error (UART_RX_PARITY_EN only)
//
// state  | meaning
// IDLE   | waiting for a synchronized 1->0 edge
// START  | half-bit wait, then confirm start bit is still low
// DATA   | sampling 8 data bits LSB first at mid-bit
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit; push on 1, framing error on 0
// BREAK  | line held low after a framing error; wait for it to go high
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          uart_rxd_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          err_frame_o,
  output logic                          err_overrun_o,
  input  logic                          err_clr_i
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          err_parity_o
`endif
);

  localparam logic [15:0] LP_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  LP_LAST = 3'(UART_DATA_BITS - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_sync_vld;
  logic       r_rx_q;

  rx_state_e  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  uart_byte_t  r_shreg;
  logic        r_err_frame;
  logic        r_err_overrun;

  rx_state_e  w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_idx_nxt;
  uart_byte_t  w_shreg_nxt;
  logic        w_tc;
  logic        w_fall;
  logic        w_push;
  logic        w_pop;
  logic        w_frame_evt;
  logic        w_overrun_evt;

  logic        w_full;
  logic        w_empty;
  uart_byte_t  w_fifo_data;

`ifdef UART_RX_PARITY_EN
  logic        r_par_bad;
  logic        r_err_parity;
  logic        w_par_bad_nxt;
  logic        w_par_evt;
`endif

  // Synchronizer flops preset high so reset looks like an idle line.
  // r_sync_vld marks when r_sync2 holds a real line sample; r_rx_q only
  // tracks real samples, so a line that is already low at reset release
  // never produces a falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync_vld <= 2'b00;
      r_rx_q     <= 1'b0;
    end else begin
      r_sync1    <= uart_rxd_i;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_rx_q     <= r_sync_vld[1] ? r_sync2 : 1'b0;
    end
  end

  assign w_fall = r_rx_q && !r_sync2;
  assign w_tc   = (r_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_push      = 1'b0;
    w_frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_par_evt     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_cnt_nxt   = LP_HALF;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tc) begin
          if (!r_sync2) begin
            w_cnt_nxt   = LP_FULL;
            w_idx_nxt   = '0;
            w_state_nxt = DATA;
`ifdef UART_RX_PARITY_EN
            w_par_bad_nxt = 1'b0;
`endif
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DATA: begin
        if (w_tc) begin
          w_shreg_nxt[r_idx] = r_sync2;
          w_cnt_nxt          = LP_FULL;
          if (r_idx == LP_LAST) begin
            w_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (w_tc) begin
          // Even parity: the parity bit equals the XOR of the data bits.
          if (r_sync2 != (^r_shreg)) begin
            w_par_evt     = 1'b1;
            w_par_bad_nxt = 1'b1;
          end
          w_cnt_nxt   = LP_FULL;
          w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      STOP: begin
        if (w_tc) begin
          if (r_sync2) begin
`ifdef UART_RX_PARITY_EN
            w_push = !r_par_bad;
`else
            w_push = 1'b1;
`endif
            w_state_nxt = IDLE;
          end else begin
            w_frame_evt = 1'b1;
            w_state_nxt = BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      BREAK: begin
        if (r_sync2) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_pop         = !w_empty && rx_ready_i;
  assign w_overrun_evt = w_push && w_full && !w_pop;

  // Set has priority over clear so an error coinciding with err_clr_i sticks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_frame   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_frame_evt)    r_err_frame <= 1'b1;
      else if (err_clr_i) r_err_frame <= 1'b0;
      if (w_overrun_evt)  r_err_overrun <= 1'b1;
      else if (err_clr_i) r_err_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_par_bad    <= 1'b0;
      r_err_parity <= 1'b0;
    end else begin
      r_par_bad <= w_par_bad_nxt;
      if (w_par_evt)      r_err_parity <= 1'b1;
      else if (err_clr_i) r_err_parity <= 1'b0;
    end
  end

  assign err_parity_o = r_err_parity;
`endif

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (r_shreg_push_data()),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_empty),
    .o_level (fifo_level_o)
  );

  // The byte is complete in r_shreg by the stop-bit sample cycle.
  function automatic uart_byte_t r_shreg_push_data();
    return r_shreg;
  endfunction

  // Mask the uninitialised FIFO storage so an empty FIFO reads as 0.
  assign rx_data_o     = w_empty ? 8'h00 : w_fifo_data;
  assign rx_valid_o    = !w_empty;
  assign err_frame_o   = r_err_frame;
  assign err_overrun_o = r_err_overrun;

endmodule

// File: tb/tb_uart_rx_monitor.sv
module tb_uart_rx_monitor;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_SAMPLE = 170;
`else
  localparam int STOP_SAMPLE = 154;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] level;
  logic       err_frame;
  logic       err_overrun;
`ifdef UART_RX_PARITY_EN
  logic       err_par;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_monitor #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .uart_rxd_i    (rxd),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (ready),
    .fifo_level_o  (level),
    .err_frame_o   (err_frame),
    .err_overrun_o (err_overrun),
    .err_clr_i     (err_clr)
`ifdef UART_RX_PARITY_EN
    ,
    .err_parity_o  (err_par)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted byte is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && rx_valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h expected none", rx_data);
      end else begin
        check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the line is left at the stop-bit value afterwards.
  task automatic send_frame(input logic [7:0] b, input logic has_par,
                            input logic par, input logic stop);
    @(posedge clk);
    #1 rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    if (has_par) begin
      rxd = par;
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b);
`ifdef UART_RX_PARITY_EN
    send_frame(b, 1'b1, ^b, 1'b1);
`else
    send_frame(b, 1'b0, 1'b0, 1'b1);
`endif
    tick(4);
  endtask

  // Raises rx_ready_i for exactly the stop-bit sample cycle of this byte.
  task automatic send_byte_with_pop(input logic [7:0] b);
    fork
      send_byte(b);
      begin
        @(posedge clk);
        repeat (STOP_SAMPLE) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    ready = 1'b1;
    while ((exp_q.size() != 0 || rx_valid) && n < budget) begin
      tick(1);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: drain timeout, %0d expected bytes left, valid=%0b", nm, exp_q.size(), rx_valid);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset with the line already low: must not be treated as a start bit.
    rxd = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(1);
    check("reset_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_level", {29'h0, level}, 32'h0);
    check("reset_data", {24'h0, rx_data}, 32'h0);
    check("reset_err_frame", {31'h0, err_frame}, 32'h0);
    check("reset_err_overrun", {31'h0, err_overrun}, 32'h0);
    tick(200);
    rxd = 1'b1;
    tick(20);
    check("low_at_reset_no_frame_err", {31'h0, err_frame}, 32'h0);
    check("low_at_reset_no_push", {29'h0, level}, 32'h0);

    // Frame decode
    ready = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(8'h55);
    exp_q.push_back(8'hA3);
    send_byte(8'hA3);
    drain("decode", 100);
    check("decode_err_frame", {31'h0, err_frame}, 32'h0);
    check("decode_err_overrun", {31'h0, err_overrun}, 32'h0);

    // False start: 4-cycle glitch
    @(posedge clk);
    #1 rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(60);
    check("glitch_level", {29'h0, level}, 32'h0);
    check("glitch_err_frame", {31'h0, err_frame}, 32'h0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    drain("after_glitch", 100);

    // Framing error followed by a 40-bit break
`ifdef UART_RX_PARITY_EN
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
`else
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
`endif
    check("frame_err_set", {31'h0, err_frame}, 32'h1);
    check("frame_err_no_push", {29'h0, level}, 32'h0);
    pulse_clr();
    tick(40 * CPB);
    check("break_single_error", {31'h0, err_frame}, 32'h0);
    rxd = 1'b1;
    tick(20);
    exp_q.push_back(8'h11);
    send_byte(8'h11);
    drain("after_break", 100);
    check("break_no_new_error", {31'h0, err_frame}, 32'h0);

    // Overrun
    ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= DEPTH) exp_q.push_back(8'(b));
      send_byte(8'(b));
    end
    check("overrun_level", {29'h0, level}, 32'h4);
    check("overrun_flag", {31'h0, err_overrun}, 32'h1);
    check("overrun_head", {24'h0, rx_data}, 32'h01);
    drain("overrun_drain", 100);
    check("overrun_drained_level", {29'h0, level}, 32'h0);
    pulse_clr();
    check("overrun_cleared", {31'h0, err_overrun}, 32'h0);

    // Full FIFO with a pop in the push cycle
    ready = 1'b0;
    for (int b = 8'h21; b <= 8'h24; b++) begin
      exp_q.push_back(8'(b));
      send_byte(8'(b));
    end
    check("full_level", {29'h0, level}, 32'h4);
    exp_q.push_back(8'h25);
    send_byte_with_pop(8'h25);
    check("full_pop_level", {29'h0, level}, 32'h4);
    check("full_pop_no_overrun", {31'h0, err_overrun}, 32'h0);
    check("full_pop_head", {24'h0, rx_data}, 32'h22);
    drain("full_pop_drain", 100);

`ifdef UART_RX_PARITY_EN
    ready = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
    tick(4);
    check("parity_err_set", {31'h0, err_par}, 32'h1);
    check("parity_drop", {29'h0, level}, 32'h0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
    tick(4);
    drain("parity_ok", 100);
    pulse_clr();
    check("parity_cleared", {31'h0, err_par}, 32'h0);
`endif

    check("final_err_frame", {31'h0, err_frame}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- UART receiver that sits directly downstream of the NEORV32 core's uart_txd output.
- Decodes 8N1 serial frames into bytes and buffers them in a show-ahead FIFO.
- Presents buffered bytes on a valid/ready stream for the simulation console or a checker.
- Fully synthesizable, so it can also be used as a debug-capture block on hardware.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range is 4 to 65535.
- FIFO_DEPTH, 16, byte entries in the receive FIFO; must be a power of two, at least 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- uart_rxd_i  in  1  serial line, asynchronous, idle high; connects to the core's uart_txd.
- rx_data_o  out  8  head-of-FIFO byte.
- rx_valid_o  out  1  FIFO non-empty.
- rx_ready_i  in  1  consumer accepts rx_data_o when rx_valid_o and rx_ready_i are both high.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
- err_frame_o  out  1  sticky framing-error flag.
- err_overrun_o  out  1  sticky overrun flag.
- err_clr_i  in  1  clears both sticky flags.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- On rst_i: all outputs are 0 except as stated; FIFO empty; FSM in IDLE; synchronizer flops preset to 1.
- uart_rxd_i passes through a 2-flop synchronizer before any use, adding 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, BREAK. A 16-bit bit counter cnt and a 3-bit index idx are used.
- IDLE: on a synchronized 1 to 0 transition, load cnt = CLKS_PER_BIT/2 - 1 and go to START.
- START: when cnt reaches 0, sample the line.
  - Sample 0: load cnt = CLKS_PER_BIT - 1, idx = 0, go to DATA.
  - Sample 1: false start; return to IDLE with nothing pushed.
- DATA: each time cnt reaches 0, shift the sample into shreg[idx] (LSB first) and reload cnt. After idx = 7, go to STOP.
- STOP: when cnt reaches 0, sample the line.
  - Sample 1: push shreg into the FIFO and go to IDLE.
  - Sample 0: set err_frame_o, discard the byte, go to BREAK.
- BREAK: remain until the synchronized line reads 1, then go to IDLE. A held-low break line therefore produces exactly one framing error.
- Push latency: rx_valid_o rises on the cycle after the stop-bit sample cycle when the FIFO was empty.
- FIFO pop: occurs on rx_valid_o and rx_ready_i; the next entry appears on rx_data_o the following cycle.
- FIFO full:
  - A push while full with no pop in the same cycle drops the byte and sets err_overrun_o.
  - A push and pop in the same cycle while full is accepted; the level stays at FIFO_DEPTH.
- Push and pop in the same cycle while empty: no pop occurs, since rx_valid_o is 0; the push lands.
- Sticky flags:
  - err_clr_i clears both flags.
  - If err_clr_i coincides with a new error event, the new event wins and the flag stays 1.
- Reset mid-frame: the partial byte is discarded. After reset the FSM waits for a fresh 1 to 0 edge, so a line already low at reset release is not a start.
- cnt and idx wrap only through explicit reloads, never through free-running overflow.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, one bit long.
  - The sampled bit is compared with even parity of shreg. A mismatch sets sticky err_parity_o (extra 1-bit output, cleared by err_clr_i) and drops the byte.
  - The FSM still proceeds to STOP, which checks framing as usual.
- When not defined: frames are 8N1, the PARITY state and the err_parity_o port do not exist, and the logic is identical to the non-parity description above.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_e enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - UART_DATA_BITS = 8;
  - the uart_byte_t typedef (logic [7:0]).
- The FSM, synchronizer and counters stay in uart_rx_monitor.
- Sub-module sync_fifo, parameterized by width and depth, is instantiated once.
  - Interface: push/data_in/full, pop/data_out/empty, level.
  - Show-ahead read; reset is synchronous and active-high.

Test Plan:
- Frame decode: CLKS_PER_BIT=16; send 0x55 then 0xA3 as 8N1 with rx_ready_i=1 -> rx_data_o shows 0x55 then 0xA3, each valid for 1 cycle, with no error flags set.
- False start: send a 4-cycle low glitch -> no push, FSM back in IDLE; a following byte 0x3C is received correctly.
- Framing error: send 0x7E with a stop bit of 0, then hold the line low for 40 bits -> err_frame_o=1, exactly one error, nothing pushed; after the line returns high, 0x11 is received; err_clr_i pulse -> err_frame_o=0.
- Overrun: FIFO_DEPTH=4 with rx_ready_i=0; send 0x01..0x05 -> fifo_level_o=4 and err_overrun_o=1; draining yields 0x01..0x04, and 0x05 is lost.
- Full with simultaneous pop: FIFO holds 4 entries; hold rx_ready_i high for exactly the stop-sample-plus-1 cycle of the 5th byte -> no overrun, fifo_level_o stays 4, 5th byte is the last entry out.
- Parity (with UART_RX_PARITY_EN): send 0x0F with parity 1 -> err_parity_o=1 and byte dropped; send 0x0F with parity 0 -> byte received.
